pulse_event_sched: RTL and testbench
====================================

// Module: pulse_event_sched
// PURPOSE
// - Multi-channel "010" pulse detector with a shared, round-robin report port.
// - One 3-state detector and one saturating pending counter per input channel.
// - A round-robin scheduler shares one valid/ready event port among the channels. It reports {channel, count, overflow}.
// - Sits between raw sampled serial lines and the event/interrupt consumer. Replaces per-line detectors that drive outputs directly.
// PARAMETERS
// - N_CH   4   number of input channels (>=2)
// - CNT_W  4   pending-counter / evt_count width; saturates at 2**CNT_W-1
// - CH_W   $clog2(N_CH)   localparam, width of evt_chan
// PORTS
// - clk        in   1      single clock, all logic on posedge
// - rst_n      in   1      reset, synchronous, active-low
// - data_in    in   N_CH   sampled serial line per channel
// - en_mask    in   N_CH   1 = channel detector enabled
// - evt_valid  out  1      event held in output register
// - evt_ready  in   1      consumer accepts event when evt_valid&&evt_ready
// - evt_chan   out  CH_W   channel index of event
// - evt_count  out  CNT_W  pulses accumulated for that channel since its last report (>=1)
// - evt_ovf    out  1      pending counter saturated before this report
// - pend_any   out  1      OR of all channel counters != 0 (excludes output register)
// BEHAVIOUR
// - Reset, sync on rst_n==0 at posedge:
//   - all detectors IDLE, counters 0, ovf flags 0
//   - evt_valid/evt_chan/evt_count/evt_ovf = 0, RR pointer = 0
//   - reset overrides an in-flight handshake; the held event is dropped
// - Detector FSM per channel, registered:
//   - IDLE:   0->SEEN0, 1->IDLE
//   - SEEN0:  1->SEEN01, 0->SEEN0
//   - SEEN01: 0->SEEN0 and raise pulse; 1->IDLE
//   - Overlap counts: 0,1,0,1,0 = 2 pulses. 0,1,1,0 = 0 pulses.
//   - en_mask[i]=0 forces IDLE and no pulse. The channel's pending count and ovf are retained and still reported.
// - Pulse timing: pulse is combinational from state + data_in at the edge where the closing 0 is sampled. The counter increments at that edge.
// - Counter: +1 per pulse, saturating at max. Saturation with another pulse sets ovf (sticky until reported).
// - Load condition: load = !evt_valid || evt_ready.
// - On load, the scheduler picks the first channel with count!=0, searching from RR pointer (ptr, ptr+1, ..., wrapping mod N_CH).
//   - Writes evt_chan, evt_count (current counter value), evt_ovf and sets evt_valid=1.
//   - Clears that channel's counter and ovf.
//   - Sets RR pointer = chan+1 mod N_CH.
// - No candidate on load: evt_valid=0, pointer unchanged.
// - Simultaneous pulse and load on the same channel: counter becomes 1, not 0; the pulse is never lost. A pulse on a saturated channel being loaded also gives 1.
// - Latency: closing 0 sampled at edge t -> counter at t -> evt_valid at t+1 (if output free and channel granted).
// - Back-to-back: one event per cycle while evt_ready=1 and counters are pending.
// - Stall: while evt_valid && !evt_ready, all evt_* outputs hold stable. Counters keep accumulating.
// STRUCTURE
// - Package pulse_pkg: detector state localparams (IDLE=2'b00, SEEN0=2'b01, SEEN01=2'b10), shared with other pulse blocks.
// - Sub-module pulse_chan_det: one per channel, via generate.
//   - Contains the FSM, saturating counter and ovf flag.
//   - I/O: clk, rst_n, en, din, clr, count, ovf, pulse.
// - Top level: RR priority search (rotate-and-priority-encode), output register and pointer.
// TESTING
// - 1. ch0 en, ready=1, data_in[0]=0,1,0 -> one cycle evt_valid, chan=0, count=1, ovf=0, one edge after the final 0 is sampled.
// - 2. ch1, ready=0, stream 0,1,0,1,0 then ready=1 -> single event chan=1, count=2. Stream 0,1,1,0 -> no event.
// - 3. ch0, ch2 and ch3 pulse in the same cycle, ready=1 -> events chan 0,2,3 on consecutive cycles. Next single ch0 pulse is granted after ch3 (pointer=0).
// - 4. CNT_W=4, ready=0, 17 pulses on ch2 -> count=15, ovf=1. After acceptance the counter is 0 and the next report has ovf=0.
// - 5. Pulse on ch1 in the exact cycle ch1 is loaded (count=3) -> event count=3, then a second event chan=1 count=1.
// - 6. evt_valid=1 stalled with pending counters, rst_n=0 for one edge -> evt_valid=0, pend_any=0 after that edge. No event is emitted afterwards without new pulses.

Source files
------------

// File: rtl/pulse_pkg.sv
// ---------------------------------------------------------------------------
// pulse_pkg
// Shared definitions for the pulse-detection blocks.
//   det_state_e : state encoding of the "010" pulse detector
//   rr_index()  : wrap-around channel index used by round-robin searches
// No ports (package).
// ---------------------------------------------------------------------------
package pulse_pkg;

  // Detector states; the encodings are fixed so other pulse blocks that
  // decode raw state bits stay compatible.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SEEN0  = 2'b01,
    SEEN01 = 2'b10
  } det_state_e;

  // Channel visited at step 'offset' of a search that starts at 'base'.
  function automatic int rr_index(input int base, input int offset, input int n);
    return (base + offset) % n;
  endfunction

endpackage

// File: rtl/pulse_chan_det.sv
// ---------------------------------------------------------------------------
// pulse_chan_det
// One channel: "010" detector FSM (overlapping), saturating pending counter
// and sticky overflow flag.
// Ports:
//   clk    in   clock, posedge
//   rst_n  in   synchronous active-low reset
//   en     in   detector enable; 0 forces IDLE, counter/ovf are kept
//   din    in   sampled serial line
//   clr    in   scheduler took this channel's count this cycle
//   count  out  pending pulses since the last report
//   ovf    out  a pulse arrived while the counter was saturated
//   pulse  out  combinational strobe, closing 0 of a "010" seen this cycle
// ---------------------------------------------------------------------------
module pulse_chan_det
  import pulse_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             din,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             ovf,
  output logic             pulse
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  det_state_e       state;
  det_state_e       state_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // After a pulse we return to SEEN0, so the closing 0 can start the next
  // pattern (0,1,0,1,0 gives two pulses).
  always_comb begin
    state_nxt = state;
    pulse     = 1'b0;
    if (!en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = din ? IDLE : SEEN0;
        SEEN0:   state_nxt = din ? SEEN01 : SEEN0;
        SEEN01: begin
          if (din) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = SEEN0;
            pulse     = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // A clear and a pulse in the same cycle leave a count of 1, so a pulse
  // arriving while the channel is being reported is never lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (clr) begin
      cnt_q <= pulse ? CNT_ONE : '0;
      ovf_q <= 1'b0;
    end else if (pulse) begin
      if (cnt_q == CNT_MAX) begin
        ovf_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + CNT_ONE;
      end
    end
  end

  assign count = cnt_q;
  assign ovf   = ovf_q;

endmodule

// File: rtl/pulse_event_sched.sv
// ---------------------------------------------------------------------------
// pulse_event_sched
// Multi-channel "010" pulse detector sharing one valid/ready event port.
// Each channel accumulates pulses; a round-robin scheduler reports
// {channel, count, overflow} and clears the reported channel.
// Ports:
//   clk        in   clock, posedge
//   rst_n      in   synchronous active-low reset
//   data_in    in   [N_CH]   sampled serial lines
//   en_mask    in   [N_CH]   per-channel detector enable
//   evt_valid  out           output register holds an event
//   evt_ready  in            consumer accepts when evt_valid && evt_ready
//   evt_chan   out  [CH_W]   reported channel
//   evt_count  out  [CNT_W]  pulses accumulated since that channel's last report
//   evt_ovf    out           counter saturated before this report
//   pend_any   out           some channel counter is non-zero
// ---------------------------------------------------------------------------
module pulse_event_sched
  import pulse_pkg::*;
#(
  parameter  int N_CH  = 4,
  parameter  int CNT_W = 4,
  localparam int CH_W  = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  data_in,
  input  logic [N_CH-1:0]  en_mask,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CH_W-1:0]  evt_chan,
  output logic [CNT_W-1:0] evt_count,
  output logic             evt_ovf,
  output logic             pend_any
);

  logic [CNT_W-1:0] ch_count [N_CH];
  logic [N_CH-1:0]  ch_ovf;
  logic [N_CH-1:0]  ch_pulse;
  logic [N_CH-1:0]  ch_clr;
  logic [N_CH-1:0]  ch_req;

  logic [CH_W-1:0]  rr_ptr;
  logic [CH_W-1:0]  ptr_next;
  logic [CH_W-1:0]  grant;
  logic [CH_W-1:0]  idx;
  logic             found;
  logic             load;

  // Pulse strobes are not needed here; the counters already absorb them.
  // They remain on the sub-module for debug probing.
  logic             unused_pulse;

  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_chan
      pulse_chan_det #(
        .CNT_W (CNT_W)
      ) u_det (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en_mask[i]),
        .din   (data_in[i]),
        .clr   (ch_clr[i]),
        .count (ch_count[i]),
        .ovf   (ch_ovf[i]),
        .pulse (ch_pulse[i])
      );
      assign ch_req[i] = |ch_count[i];
    end
  endgenerate

  assign unused_pulse = ^ch_pulse;
  assign pend_any     = |ch_req;

  // The output register can take a new event when empty or being drained.
  assign load = !evt_valid || evt_ready;

  // Round-robin search: first requesting channel visited from rr_ptr upward,
  // wrapping, so the most recently served channel has lowest priority.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int k = 0; k < N_CH; k++) begin
      idx = CH_W'(rr_index(int'(rr_ptr), k, N_CH));
      if (!found && ch_req[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  // The pointer moves just past the served channel; written explicitly so a
  // non-power-of-two N_CH still wraps to 0.
  always_comb begin
    ptr_next = grant + CH_W'(1);
    if (grant == CH_W'(N_CH - 1)) begin
      ptr_next = '0;
    end
  end

  // Clear only the channel whose count is copied into the output register.
  always_comb begin
    ch_clr = '0;
    if (load && found) begin
      ch_clr[grant] = 1'b1;
    end
  end

  // Output register and round-robin pointer. Nothing changes on a stall, so
  // all evt_* outputs hold while the consumer is not ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      evt_valid <= 1'b0;
      evt_chan  <= '0;
      evt_count <= '0;
      evt_ovf   <= 1'b0;
      rr_ptr    <= '0;
    end else if (load) begin
      if (found) begin
        evt_valid <= 1'b1;
        evt_chan  <= grant;
        evt_count <= ch_count[grant];
        evt_ovf   <= ch_ovf[grant];
        rr_ptr    <= ptr_next;
      end else begin
        evt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pulse_event_sched.sv
// ---------------------------------------------------------------------------
// tb_pulse_event_sched
// Directed testbench for pulse_event_sched (N_CH=4, CNT_W=4). Inputs change
// 1 time unit after each rising edge; outputs are checked at the same point,
// so every check sees the state left by the edge just taken.
// ---------------------------------------------------------------------------
module tb_pulse_event_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] data_in;
  logic [3:0] en_mask;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_chan;
  logic [3:0] evt_count;
  logic       evt_ovf;
  logic       pend_any;

  int checkCount = 0;
  int failCount  = 0;

  always #5 clk = ~clk;

  pulse_event_sched #(
    .N_CH  (4),
    .CNT_W (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .en_mask   (en_mask),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_chan  (evt_chan),
    .evt_count (evt_count),
    .evt_ovf   (evt_ovf),
    .pend_any  (pend_any)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Checks evt_valid, and the event fields when an event is expected.
  task automatic checkEvent(input string tag, input logic valid, input int chan,
                            input int count, input logic ovf);
    checkOutput({tag, "_valid"}, 32'(evt_valid), 32'(valid));
    if (valid) begin
      checkOutput({tag, "_chan"},  32'(evt_chan),  32'(chan));
      checkOutput({tag, "_count"}, 32'(evt_count), 32'(count));
      checkOutput({tag, "_ovf"},   32'(evt_ovf),   32'(ovf));
    end
  endtask

  // Drive one cycle of inputs, take the edge, settle just after it.
  task automatic applyStimulus(input logic [3:0] data, input logic [3:0] mask,
                               input logic ready);
    data_in   = data;
    en_mask   = mask;
    evt_ready = ready;
    @(posedge clk);
    #1;
  endtask

  // All lines idle high except channel ch, which carries bit b.
  function automatic logic [3:0] lineBits(input int ch, input logic b);
    logic [3:0] v;
    v = 4'b1111;
    v[ch[1:0]] = b;
    return v;
  endfunction

  // Send 'len' bits on channel ch, MSB of 'bits' first.
  task automatic sendSerial(input int ch, input logic [31:0] bits, input int len,
                            input logic [3:0] mask, input logic ready);
    for (int i = len - 1; i >= 0; i--) begin
      applyStimulus(lineBits(ch, bits[i]), mask, ready);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    data_in   = 4'b1111;
    en_mask   = 4'b0000;
    evt_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkEvent("rst", 1'b0, 0, 0, 1'b0);
    checkOutput("rst_chan",  32'(evt_chan),  32'd0);
    checkOutput("rst_count", 32'(evt_count), 32'd0);
    checkOutput("rst_ovf",   32'(evt_ovf),   32'd0);
    checkOutput("rst_pend",  32'(pend_any),  32'd0);
    rst_n = 1'b1;

    // Test 1: single 0,1,0 on ch0; counter at the closing edge, event one later.
    sendSerial(0, 32'b010, 3, 4'b0001, 1'b1);
    checkEvent("t1_early", 1'b0, 0, 0, 1'b0);
    checkOutput("t1_pend", 32'(pend_any), 32'd1);
    applyStimulus(4'b1111, 4'b0001, 1'b1);
    checkEvent("t1_evt", 1'b1, 0, 1, 1'b0);
    checkOutput("t1_pend_clr", 32'(pend_any), 32'd0);
    applyStimulus(4'b1111, 4'b0001, 1'b1);
    checkEvent("t1_gone", 1'b0, 0, 0, 1'b0);

    // Test 2: ch0 event parked (ready=0), overlapping 0,1,0,1,0 on ch1 -> 2.
    sendSerial(0, 32'b010, 3, 4'b0011, 1'b0);
    applyStimulus(4'b1111, 4'b0011, 1'b0);
    checkEvent("t2_park", 1'b1, 0, 1, 1'b0);
    sendSerial(1, 32'b01010, 5, 4'b0011, 1'b0);
    checkEvent("t2_stall", 1'b1, 0, 1, 1'b0);
    checkOutput("t2_pend", 32'(pend_any), 32'd1);
    applyStimulus(4'b1111, 4'b0011, 1'b1);
    checkEvent("t2_evt", 1'b1, 1, 2, 1'b0);
    applyStimulus(4'b1111, 4'b0011, 1'b1);
    checkEvent("t2_gone", 1'b0, 0, 0, 1'b0);
    // 0,1,1,0 is not a pulse
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        applyStimulus(lineBits(1, (i == 1 || i == 2)), 4'b0011, 1'b1);
      end else begin
        applyStimulus(4'b1111, 4'b0011, 1'b1);
      end
      checkOutput("t2_0110_valid", 32'(evt_valid), 32'd0);
      checkOutput("t2_0110_pend",  32'(pend_any),  32'd0);
    end
    // A disabled channel never counts
    sendSerial(3, 32'b01010, 5, 4'b0011, 1'b1);
    applyStimulus(4'b1111, 4'b0011, 1'b1);
    checkOutput("t2_masked_pend",  32'(pend_any),  32'd0);
    checkOutput("t2_masked_valid", 32'(evt_valid), 32'd0);

    // Reset so the round-robin pointer starts at 0 for test 3.
    rst_n = 1'b0;
    applyStimulus(4'b1111, 4'b0000, 1'b1);
    rst_n = 1'b1;

    // Test 3: ch0, ch2, ch3 pulse together -> 0, 2, 3 on consecutive cycles.
    applyStimulus(4'b0010, 4'b1111, 1'b1);
    applyStimulus(4'b1111, 4'b1111, 1'b1);
    applyStimulus(4'b0010, 4'b1111, 1'b1);
    checkEvent("t3_early", 1'b0, 0, 0, 1'b0);
    checkOutput("t3_pend", 32'(pend_any), 32'd1);
    applyStimulus(4'b1111, 4'b1111, 1'b1);
    checkEvent("t3_e0", 1'b1, 0, 1, 1'b0);
    applyStimulus(4'b1111, 4'b1111, 1'b1);
    checkEvent("t3_e2", 1'b1, 2, 1, 1'b0);
    applyStimulus(4'b1111, 4'b1111, 1'b1);
    checkEvent("t3_e3", 1'b1, 3, 1, 1'b0);
    applyStimulus(4'b1111, 4'b1111, 1'b1);
    checkEvent("t3_gone", 1'b0, 0, 0, 1'b0);
    checkOutput("t3_pend_clr", 32'(pend_any), 32'd0);
    // Pointer wrapped to 0: simultaneous ch0/ch2 pulses serve ch0 first.
    applyStimulus(4'b1010, 4'b1111, 1'b1);
    applyStimulus(4'b1111, 4'b1111, 1'b1);
    applyStimulus(4'b1010, 4'b1111, 1'b1);
    applyStimulus(4'b1111, 4'b1111, 1'b1);
    checkEvent("t3_wrap0", 1'b1, 0, 1, 1'b0);
    applyStimulus(4'b1111, 4'b1111, 1'b1);
    checkEvent("t3_wrap2", 1'b1, 2, 1, 1'b0);
    applyStimulus(4'b1111, 4'b1111, 1'b1);
    checkEvent("t3_wrap_gone", 1'b0, 0, 0, 1'b0);

    // Test 4: first ch2 pulse parks in the output; 17 more saturate -> 15/ovf.
    applyStimulus(lineBits(2, 1'b0), 4'b0100, 1'b0);
    for (int i = 0; i < 18; i++) begin
      applyStimulus(lineBits(2, 1'b1), 4'b0100, 1'b0);
      applyStimulus(lineBits(2, 1'b0), 4'b0100, 1'b0);
    end
    applyStimulus(4'b1111, 4'b0100, 1'b0);
    checkEvent("t4_stall", 1'b1, 2, 1, 1'b0);
    checkOutput("t4_pend", 32'(pend_any), 32'd1);
    applyStimulus(4'b1111, 4'b0100, 1'b1);
    checkEvent("t4_sat", 1'b1, 2, 15, 1'b1);
    applyStimulus(4'b1111, 4'b0100, 1'b1);
    checkEvent("t4_gone", 1'b0, 0, 0, 1'b0);
    checkOutput("t4_pend_clr", 32'(pend_any), 32'd0);
    sendSerial(2, 32'b010, 3, 4'b0100, 1'b1);
    applyStimulus(4'b1111, 4'b0100, 1'b1);
    checkEvent("t4_after", 1'b1, 2, 1, 1'b0);
    applyStimulus(4'b1111, 4'b0100, 1'b1);
    checkEvent("t4_after_gone", 1'b0, 0, 0, 1'b0);

    // Test 5: pulse on ch1 in the same cycle its count of 3 is loaded.
    sendSerial(1, 32'b010101010, 9, 4'b0010, 1'b0);
    applyStimulus(lineBits(1, 1'b1), 4'b0010, 1'b0);
    checkEvent("t5_stall", 1'b1, 1, 1, 1'b0);
    applyStimulus(lineBits(1, 1'b0), 4'b0010, 1'b1);
    checkEvent("t5_evt3", 1'b1, 1, 3, 1'b0);
    checkOutput("t5_pend_kept", 32'(pend_any), 32'd1);
    applyStimulus(4'b1111, 4'b0010, 1'b1);
    checkEvent("t5_evt1", 1'b1, 1, 1, 1'b0);
    checkOutput("t5_pend_clr", 32'(pend_any), 32'd0);
    applyStimulus(4'b1111, 4'b0010, 1'b1);
    checkEvent("t5_gone", 1'b0, 0, 0, 1'b0);

    // Test 6: reset during a stall with a pending count drops everything.
    sendSerial(0, 32'b01010, 5, 4'b0001, 1'b0);
    checkEvent("t6_stall", 1'b1, 0, 1, 1'b0);
    checkOutput("t6_pend", 32'(pend_any), 32'd1);
    rst_n = 1'b0;
    applyStimulus(4'b1111, 4'b0001, 1'b0);
    checkOutput("t6_rst_valid", 32'(evt_valid), 32'd0);
    checkOutput("t6_rst_pend",  32'(pend_any),  32'd0);
    checkOutput("t6_rst_count", 32'(evt_count), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b1111, 4'b0001, 1'b1);
      checkOutput("t6_quiet", 32'(evt_valid), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
